// File: rtl/differentiator_comb_pkg.sv
// Shared types and constants for the saturating comb (first-difference) stage.
package differentiator_comb_pkg;

    // Default sample width and the clamp limits that go with it.
    localparam int SAMPLE_W = 10;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Largest / smallest value representable in a w-bit two's complement word.
    function automatic int sat_max_f(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min_f(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max_f(SAMPLE_W);   // 511
    localparam int SAT_MIN = sat_min_f(SAMPLE_W);   // -512

    // FILL until DELAY samples have been accepted, then RUN.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_e;

endpackage

// File: rtl/differentiator_satminus.sv
// Combinational saturating subtract y = clamp(a - b); sat flags a clamped result.
module differentiator_satminus
    import differentiator_comb_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_y,
    output logic                    o_sat
);

    localparam int MAXV = (WIDTH == SAMPLE_W) ? SAT_MAX : sat_max_f(WIDTH);
    localparam int MINV = (WIDTH == SAMPLE_W) ? SAT_MIN : sat_min_f(WIDTH);

    // Limits sign-extended into the one-bit-wider difference domain.
    localparam logic signed [WIDTH:0] D_MAX = (WIDTH+1)'(MAXV);
    localparam logic signed [WIDTH:0] D_MIN = (WIDTH+1)'(MINV);

    logic signed [WIDTH:0] w_d;
    logic                  w_hi;
    logic                  w_lo;

    // The extra bit makes the raw difference exact before clamping.
    assign w_d  = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_hi = (w_d > D_MAX);
    assign w_lo = (w_d < D_MIN);

    // Clamp to the representable range and flag when it happened.
    always_comb begin
        o_y   = w_d[WIDTH-1:0];
        o_sat = 1'b0;
        if (w_hi) begin
            o_y   = D_MAX[WIDTH-1:0];
            o_sat = 1'b1;
        end else if (w_lo) begin
            o_y   = D_MIN[WIDTH-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/differentiator_comb.sv
// Saturating comb stage y[n] = sat(x[n] - x[n-DELAY]) on a valid/ready stream,
// with a single output register giving full throughput and 1-cycle latency.
module differentiator_comb
    import differentiator_comb_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DELAY = 1
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_sat,
    output logic                    primed
);

    localparam logic [3:0] DLY    = 4'(DELAY);
    localparam logic [3:0] DLY_M1 = 4'(DELAY - 1);

    logic signed [WIDTH-1:0] r_hist [DELAY];
    logic [3:0]              r_cnt;
    fill_state_e             r_state;
    fill_state_e             w_state_nxt;
    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_out_data;
    logic                    r_out_sat;
    logic                    w_acc;
    logic signed [WIDTH-1:0] w_y;
    logic                    w_sat;

    // Ready whenever the output slot is empty or being drained; clr blocks input.
    assign in_ready  = ~clr & (~r_out_valid | out_ready);
    assign w_acc     = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign primed    = (r_state == RUN);

    differentiator_satminus #(.WIDTH(WIDTH)) u_satminus (
        .i_a   (in_data),
        .i_b   (r_hist[DELAY-1]),
        .o_y   (w_y),
        .o_sat (w_sat)
    );

    // History shift register; zero history makes pre-stream samples read as 0.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < DELAY; i++) r_hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DELAY; i++) r_hist[i] <= '0;
        end else if (w_acc) begin
            r_hist[0] <= in_data;
            for (int i = 1; i < DELAY; i++) r_hist[i] <= r_hist[i-1];
        end
    end

    // Fill counter saturates at DELAY so it never wraps back into FILL.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_acc && (r_cnt != DLY)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Fill state register.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) r_state <= FILL;
        else                  r_state <= w_state_nxt;
    end

    // Move to RUN on the DELAY-th accept; only clr (or reset) returns to FILL.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = FILL;
        end else if ((r_state == FILL) && w_acc && (r_cnt == DLY_M1)) begin
            w_state_nxt = RUN;
        end
    end

    // Output register: load on accept, drop valid on drain, hold otherwise.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_y;
            r_out_sat   <= w_sat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_differentiator_comb.sv
// Scoreboard bench for differentiator_comb: one DELAY=1 and one DELAY=4 instance.
module tb_differentiator_comb;
    import differentiator_comb_pkg::*;

    typedef struct {
        logic signed [9:0] data;
        logic              sat;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic              clr1 = 1'b0, i1_valid = 1'b0, o1_ready = 1'b1;
    sample_t           i1_data = '0;
    logic              i1_ready, o1_valid, o1_sat, primed1;
    logic signed [9:0] o1_data;

    logic              clr4 = 1'b0, i4_valid = 1'b0, o4_ready = 1'b1;
    sample_t           i4_data = '0;
    logic              i4_ready, o4_valid, o4_sat, primed4;
    logic signed [9:0] o4_data;

    exp_t q1[$];
    exp_t q4[$];
    exp_t m1_e, m4_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    differentiator_comb #(.WIDTH(10), .DELAY(1)) dut1 (
        .system1000(clk), .system1000_rstn(rstn), .clr(clr1),
        .in_valid(i1_valid), .in_data(i1_data), .in_ready(i1_ready),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data),
        .out_sat(o1_sat), .primed(primed1)
    );

    differentiator_comb #(.WIDTH(10), .DELAY(4)) dut4 (
        .system1000(clk), .system1000_rstn(rstn), .clr(clr4),
        .in_valid(i4_valid), .in_data(i4_data), .in_ready(i4_ready),
        .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data),
        .out_sat(o4_sat), .primed(primed4)
    );

    // Scoreboard monitors: every transfer pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (rstn && o1_valid && o1_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL d1_unexpected_output got data=%0d sat=%0d", o1_data, o1_sat);
            end else begin
                m1_e = q1.pop_front();
                if (o1_data !== m1_e.data || o1_sat !== m1_e.sat) begin
                    errors++;
                    $display("FAIL d1_output got data=%0d sat=%0d expected data=%0d sat=%0d",
                             o1_data, o1_sat, m1_e.data, m1_e.sat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && o4_valid && o4_ready) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL d4_unexpected_output got data=%0d sat=%0d", o4_data, o4_sat);
            end else begin
                m4_e = q4.pop_front();
                if (o4_data !== m4_e.data || o4_sat !== m4_e.sat) begin
                    errors++;
                    $display("FAIL d4_output got data=%0d sat=%0d expected data=%0d sat=%0d",
                             o4_data, o4_sat, m4_e.data, m4_e.sat);
                end
            end
        end
    end

    task automatic send1(input logic signed [9:0] x, input logic signed [9:0] ey, input logic es);
        int n = 0;
        q1.push_back(exp_t'{ey, es});
        i1_valid = 1'b1;
        i1_data  = x;
        @(negedge clk);
        while (!i1_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!i1_ready) begin
            checks++; errors++;
            $display("FAIL d1_accept_timeout in_ready=%0d expected 1", i1_ready);
        end
        @(posedge clk); #1;
        i1_valid = 1'b0;
    endtask

    task automatic send4(input logic signed [9:0] x, input logic signed [9:0] ey, input logic es);
        int n = 0;
        q4.push_back(exp_t'{ey, es});
        i4_valid = 1'b1;
        i4_data  = x;
        @(negedge clk);
        while (!i4_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!i4_ready) begin
            checks++; errors++;
            $display("FAIL d4_accept_timeout in_ready=%0d expected 1", i4_ready);
        end
        @(posedge clk); #1;
        i4_valid = 1'b0;
    endtask

    task automatic drain_all();
        int n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending d1=%0d d4=%0d expected 0 0", q1.size(), q4.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic clear1();
        drain_all();
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o1_valid !== 1'b0 || o1_data !== 10'sd0 || o1_sat !== 1'b0 || primed1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got v=%0d d=%0d s=%0d p=%0d expected 0 0 0 0",
                     o1_valid, o1_data, o1_sat, primed1);
        end
        checks++;
        if (i1_ready !== 1'b1 || i4_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0d/%0d expected 1/1", i1_ready, i4_ready);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        // Park one output in the register, then reset asynchronously mid-cycle.
        o1_ready = 1'b0;
        i1_valid = 1'b1;
        i1_data  = 10'sd5;
        @(posedge clk); #1;
        i1_valid = 1'b0;
        checks++;
        if (o1_valid !== 1'b1 || o1_data !== 10'sd5 || primed1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold got v=%0d d=%0d p=%0d expected 1 5 1", o1_valid, o1_data, primed1);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (o1_valid !== 1'b0 || o1_data !== 10'sd0 || primed1 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%0d d=%0d p=%0d expected 0 0 0", o1_valid, o1_data, primed1);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        o1_ready = 1'b1;
        checks++;
        if (i1_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %0d expected 1", i1_ready);
        end
    endtask

    task automatic test_stream();
        send1(10'sd5, 10'sd5, 1'b0);
        checks++;
        if (o1_valid !== 1'b1 || o1_data !== 10'sd5) begin
            errors++;
            $display("FAIL latency got v=%0d d=%0d expected 1 5", o1_valid, o1_data);
        end
        send1(10'sd7, 10'sd2, 1'b0);
        send1(10'sd3, -10'sd4, 1'b0);
        drain_all();
    endtask

    task automatic test_saturation();
        clear1();
        send1(10'sd511,  10'sd511,  1'b0);
        send1(-10'sd512, -10'sd512, 1'b1);
        send1(10'sd511,  10'sd511,  1'b1);
        send1(10'sd0,    -10'sd511, 1'b0);
        send1(-10'sd512, -10'sd512, 1'b0);
        drain_all();
    endtask

    task automatic test_backpressure();
        clear1();
        o1_ready = 1'b0;
        send1(10'sd10, 10'sd10, 1'b0);
        q1.push_back(exp_t'{10'sd15, 1'b0});
        i1_valid = 1'b1;
        i1_data  = 10'sd25;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (i1_ready !== 1'b0 || o1_data !== 10'sd10 || o1_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold got ready=%0d v=%0d d=%0d expected 0 1 10", i1_ready, o1_valid, o1_data);
            end
        end
        @(posedge clk); #1;
        o1_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (i1_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %0d expected 1", i1_ready);
        end
        @(posedge clk); #1;
        i1_valid = 1'b0;
        send1(10'sd30, 10'sd5, 1'b0);
        drain_all();
    endtask

    task automatic test_inverse();
        clear1();
        send1(10'sd3,  10'sd3,   1'b0);
        send1(10'sd1,  -10'sd2,  1'b0);
        send1(10'sd11, 10'sd10,  1'b0);
        send1(10'sd11, 10'sd0,   1'b0);
        send1(-10'sd9, -10'sd20, 1'b0);
        drain_all();
    endtask

    task automatic test_delay4();
        send4(10'sd1, 10'sd1, 1'b0);
        send4(10'sd2, 10'sd2, 1'b0);
        send4(10'sd3, 10'sd3, 1'b0);
        checks++;
        if (primed4 !== 1'b0) begin
            errors++;
            $display("FAIL d4_primed_early got %0d expected 0", primed4);
        end
        send4(10'sd4, 10'sd4, 1'b0);
        checks++;
        if (primed4 !== 1'b1) begin
            errors++;
            $display("FAIL d4_primed got %0d expected 1", primed4);
        end
        send4(10'sd10, 10'sd9, 1'b0);
        // Upstream presents 6 during clr; it must wait until clr drops.
        clr4     = 1'b1;
        i4_valid = 1'b1;
        i4_data  = 10'sd6;
        #1;
        checks++;
        if (i4_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_in_ready got %0d expected 0", i4_ready);
        end
        @(posedge clk); #1;
        clr4 = 1'b0;
        checks++;
        if (o4_valid !== 1'b0 || o4_data !== 10'sd0 || o4_sat !== 1'b0 || primed4 !== 1'b0) begin
            errors++;
            $display("FAIL clr_effect got v=%0d d=%0d s=%0d p=%0d expected 0 0 0 0",
                     o4_valid, o4_data, o4_sat, primed4);
        end
        send4(10'sd6, 10'sd6, 1'b0);
        drain_all();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_saturation();
        test_backpressure();
        test_inverse();
        test_delay4();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
